// File: rtl/alu_op_sequencer.sv
// Button-driven operation sequencer for the register file and ALU.
// Debounces the trigger, latches the opcode and issues registered strobes.
module alu_op_sequencer #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_BITS   = 16,
  parameter int ALU_LAT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [3:0] op,
  input  logic       auto_wb,
  output logic       load_a,
  output logic       load_b,
  output logic       swap,
  output logic       store,
  output logic       alu_trigger,
  output logic [3:0] op_q,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    EXEC,
    WB,
    DONE,
    RELEASE
  } state_t;

  localparam int EW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_CYCLES - 1);
  localparam logic [EW-1:0] EXEC_LAST = EW'(ALU_LAT - 1);

  logic sync1;
  logic sync2;
  logic btn_db;
  logic btn_db_q;
  logic [DB_BITS-1:0] db_cnt;
  logic press;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_db_q <= btn_db;
      if (sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_BITS'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  state_t state;
  state_t state_n;
  logic [EW-1:0] exec_cnt;
  logic [EW-1:0] exec_cnt_n;
  logic [3:0] op_n;
  logic is_alu;
  logic la_n;
  logic lb_n;
  logic sw_n;
  logic st_n;

  // Opcodes 1100..1111 address the register file; the rest go to the ALU.
  assign is_alu = ~(op_q[3] & op_q[2]);

  always_comb begin
    state_n    = state;
    op_n       = op_q;
    exec_cnt_n = exec_cnt;
    unique case (state)
      IDLE: begin
        if (press) begin
          op_n    = op;
          state_n = DISPATCH;
        end
      end
      DISPATCH: begin
        if (is_alu) begin
          state_n    = EXEC;
          exec_cnt_n = EXEC_LAST;
        end else begin
          state_n = DONE;
        end
      end
      EXEC: begin
        if (exec_cnt == '0) begin
          state_n = auto_wb ? WB : DONE;
        end else begin
          exec_cnt_n = exec_cnt - EW'(1);
        end
      end
      WB:      state_n = DONE;
      DONE:    state_n = RELEASE;
      RELEASE: begin
        if (!btn_db) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    la_n = 1'b0;
    lb_n = 1'b0;
    sw_n = 1'b0;
    st_n = (state_n == WB);
    if (state_n == DISPATCH) begin
      unique case (1'b1)
        (op_n == 4'b1111): la_n = 1'b1;
        (op_n == 4'b1101): lb_n = 1'b1;
        (op_n == 4'b1110): sw_n = 1'b1;
        (op_n == 4'b1100): st_n = 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      exec_cnt    <= '0;
      op_q        <= 4'd0;
      load_a      <= 1'b0;
      load_b      <= 1'b0;
      swap        <= 1'b0;
      store       <= 1'b0;
      alu_trigger <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      op_count    <= 8'd0;
    end else begin
      state       <= state_n;
      exec_cnt    <= exec_cnt_n;
      op_q        <= op_n;
      load_a      <= la_n;
      load_b      <= lb_n;
      swap        <= sw_n;
      store       <= st_n;
      alu_trigger <= (state_n == EXEC);
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      op_count    <= op_count + 8'(state_n == DONE);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a done-driven scoreboard.
// Expected operations are queued at press time and retired on each done.
module tb_alu_op_sequencer;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic auto_wb = 1'b0;
  logic [3:0] op = 4'd0;
  logic load_a;
  logic load_b;
  logic swap;
  logic store;
  logic alu_trigger;
  logic [3:0] op_q;
  logic busy;
  logic done;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DB_CYCLES(4),
    .DB_BITS(4),
    .ALU_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .op(op),
    .auto_wb(auto_wb),
    .load_a(load_a),
    .load_b(load_b),
    .swap(swap),
    .store(store),
    .alu_trigger(alu_trigger),
    .op_q(op_q),
    .busy(busy),
    .done(done),
    .op_count(op_count)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] cnt;
    int na;
    int nb;
    int nsw;
    int nst;
    int nalu;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int acc_a = 0;
  int acc_b = 0;
  int acc_sw = 0;
  int acc_st = 0;
  int acc_alu = 0;
  logic [7:0] model_cnt = 8'd0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [3:0] o,
                                      input logic wb,
                                      input logic [7:0] c);
    exp_t e;
    e.op = o;
    e.cnt = c;
    e.na = 0;
    e.nb = 0;
    e.nsw = 0;
    e.nst = 0;
    e.nalu = 0;
    case (o)
      4'b1111: e.na = 1;
      4'b1101: e.nb = 1;
      4'b1110: e.nsw = 1;
      4'b1100: e.nst = 1;
      default: begin
        e.nalu = LAT;
        e.nst = wb ? 1 : 0;
      end
    endcase
    return e;
  endfunction

  // Monitor: counts strobes per operation, retires the scoreboard on done.
  always @(posedge clk) begin : mon
    exp_t e;
    int hot;
    #1;
    if (reset) begin
      acc_a = 0; acc_b = 0; acc_sw = 0;
      acc_st = 0; acc_alu = 0;
    end else begin
      acc_a += int'(load_a);
      acc_b += int'(load_b);
      acc_sw += int'(swap);
      acc_st += int'(store);
      acc_alu += int'(alu_trigger);
      hot = int'(load_a) + int'(load_b) + int'(swap)
          + int'(store) + int'(alu_trigger);
      if (hot > 1) check("exclusive", hot, 1);
      if (done) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("sb_op_q", op_q, e.op);
          check("sb_count", op_count, e.cnt);
          check("sb_load_a", acc_a, e.na);
          check("sb_load_b", acc_b, e.nb);
          check("sb_swap", acc_sw, e.nsw);
          check("sb_store", acc_st, e.nst);
          check("sb_alu", acc_alu, e.nalu);
        end
        acc_a = 0; acc_b = 0; acc_sw = 0;
        acc_st = 0; acc_alu = 0;
      end
    end
  end

  // Edge indices counted from the edge that first samples btn_raw high.
  task automatic run_op(input logic [3:0] o, input logic wb,
                        output int ts, output int ta,
                        output int tst, output int td);
    model_cnt = model_cnt + 8'd1;
    sb.push_back(expect_for(o, wb, model_cnt));
    @(negedge clk);
    op = o;
    auto_wb = wb;
    btn_raw = 1'b1;
    @(posedge clk);
    ts = -1; ta = -1; tst = -1; td = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (ts < 0 && (load_a | load_b | swap | store)) ts = k;
      if (ta < 0 && alu_trigger) ta = k;
      if (tst < 0 && store) tst = k;
      if (done) begin
        td = k;
        break;
      end
    end
    if (td < 0) check("done_timeout", done, 1);
    check("count_after_op", op_count, model_cnt);
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn_raw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check("release_idle", busy, 0);
  endtask

  initial begin
    int ts, ta, tst, td;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_q", op_q, 0);
    check("rst_count", op_count, 0);
    check("rst_alu", alu_trigger, 0);
    check("rst_strobes", {load_a, load_b, swap, store}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    run_op(4'b1111, 1'b0, ts, ta, tst, td);
    check("la_latency", ts, 6);
    check("la_done", td, 7);
    check("la_count", op_count, 1);
    release_btn();

    seen = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_raw = ~btn_raw;
      @(negedge clk);
      seen = seen | busy;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | busy;
    end
    check("bounce_busy", seen, 0);
    check("bounce_count", op_count, 1);
    run_op(4'b1101, 1'b0, ts, ta, tst, td);
    check("lb_done", td, 7);
    release_btn();

    run_op(4'b0011, 1'b1, ts, ta, tst, td);
    check("wb_alu_start", ta, 7);
    check("wb_store", tst, 10);
    check("wb_done", td, 11);
    release_btn();

    run_op(4'b0000, 1'b0, ts, ta, tst, td);
    check("alu_start", ta, 7);
    check("alu_done", td, 10);
    check("alu_no_store", tst, -1);
    release_btn();

    run_op(4'b1110, 1'b0, ts, ta, tst, td);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("held_busy", busy, 1);
    check("held_extra", acc_a + acc_b + acc_sw + acc_st + acc_alu, 0);
    check("held_count", op_count, model_cnt);
    release_btn();
    run_op(4'b1110, 1'b0, ts, ta, tst, td);
    check("held_second", op_count, model_cnt);
    release_btn();

    @(negedge clk);
    op = 4'b0101;
    auto_wb = 1'b1;
    btn_raw = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (alu_trigger) break;
    end
    check("mid_exec_seen", alu_trigger, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    btn_raw = 1'b0;
    @(posedge clk);
    #1;
    model_cnt = 8'd0;
    check("mid_rst_alu", alu_trigger, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op_q", op_q, 0);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_quiet", op_count, 0);

    for (int i = 0; i < 256; i++) begin
      run_op(4'b1100, 1'b0, ts, ta, tst, td);
      release_btn();
    end
    check("wrap_count", op_count, 0);

    repeat (5) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
